// File: rtl/serial_adder_seq.sv
// Digit-serial adder/subtractor: operands captured on start, processed LSB-first
// DIGIT_WIDTH bits per clock through a registered carry, result flagged by a done pulse.
module serial_adder_seq #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned DIGIT_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  sub,
  input  logic                  cin,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  cout,
  output logic                  ovf
);

  localparam int unsigned NUM_DIGITS = DATA_WIDTH / DIGIT_WIDTH;
  localparam int unsigned CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  if (DATA_WIDTH < 2 || DIGIT_WIDTH == 0 || (DATA_WIDTH % DIGIT_WIDTH) != 0) begin : g_bad_params
    $error("serial_adder_seq: DIGIT_WIDTH must divide DATA_WIDTH (>= 2)");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [DATA_WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [DATA_WIDTH-1:0]   res_q, res_d;
  logic                    carry_q, carry_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   sum_q, sum_d;
  logic                    cout_q, cout_d;
  logic                    ovf_q, ovf_d;
  logic                    busy_q, done_q;

  logic [DIGIT_WIDTH:0]    digit_c;
  logic [DATA_WIDTH-1:0]   res_shift_c;
  logic                    accept_c;
  logic                    last_c;

  // One digit of the ripple: low digits of both shifters plus the held carry.
  assign digit_c = (DIGIT_WIDTH+1)'(a_sh_q[DIGIT_WIDTH-1:0])
                 + (DIGIT_WIDTH+1)'(b_sh_q[DIGIT_WIDTH-1:0])
                 + (DIGIT_WIDTH+1)'(carry_q);

  // New digit enters at the top; the concatenation keeps this legal when one digit spans the word.
  assign res_shift_c = DATA_WIDTH'({digit_c[DIGIT_WIDTH-1:0], res_q} >> DIGIT_WIDTH);
  assign accept_c    = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign last_c      = (cnt_q == CNT_W'(NUM_DIGITS - 1));

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        a_sh_d  = a_sh_q >> DIGIT_WIDTH;
        b_sh_d  = b_sh_q >> DIGIT_WIDTH;
        res_d   = res_shift_c;
        carry_d = digit_c[DIGIT_WIDTH];
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_c) begin
          // Sign-bit overflow form covers every digit width, including carry-in/out XOR at width 1.
          sum_d   = res_shift_c;
          cout_d  = digit_c[DIGIT_WIDTH];
          ovf_d   = (a_sh_q[DIGIT_WIDTH-1] == b_sh_q[DIGIT_WIDTH-1]) &&
                    (digit_c[DIGIT_WIDTH-1] != a_sh_q[DIGIT_WIDTH-1]);
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = start ? ST_RUN : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (accept_c) begin
      a_sh_d  = a;
      b_sh_d  = sub ? ~b : b;
      carry_d = sub | cin;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= (state_d == ST_RUN);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_seq.sv
// Directed bench for serial_adder_seq: a bit-serial and a nibble-serial instance
// checked against hand-computed sums, flags, latency and reset behaviour.
module tb_serial_adder_seq;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start1, start4;
  logic       sub, cin;
  logic [7:0] a, b;

  logic       busy1, done1, cout1, ovf1;
  logic [7:0] sum1;
  logic       busy4, done4, cout4, ovf4;
  logic [7:0] sum4;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] prev_sum [2];

  always #5 clk = ~clk;

  serial_adder_seq #(.DATA_WIDTH(8), .DIGIT_WIDTH(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .sub(sub), .cin(cin),
    .a(a), .b(b), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  serial_adder_seq #(.DATA_WIDTH(8), .DIGIT_WIDTH(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .start(start4), .sub(sub), .cin(cin),
    .a(a), .b(b), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One operation on instance sel (0: bit-serial, 1: nibble-serial); inputs are scrambled after accept.
  task automatic run_op(input string tag, input bit sel,
                        input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic ts, input logic tc,
                        input logic [7:0] es, input logic ec, input logic eo);
    int cyc;
    int nd;
    nd = sel ? 2 : 8;
    @(negedge clk);
    a = ta; b = tb_v; sub = ts; cin = tc;
    if (sel) start4 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start4 = 1'b0;
    a = ~ta; b = 8'h5A; sub = ~ts; cin = ~tc;
    check_eq({tag, "_busy"}, 32'(sel ? busy4 : busy1), 32'd1);
    check_eq({tag, "_stable"}, 32'(sel ? sum4 : sum1), 32'(prev_sum[sel]));
    cyc = 0;
    while (!(sel ? done4 : done1) && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, "_lat"}, 32'(cyc), 32'(nd));
    check_eq({tag, "_sum"}, 32'(sel ? sum4 : sum1), 32'(es));
    check_eq({tag, "_cout"}, 32'(sel ? cout4 : cout1), 32'(ec));
    check_eq({tag, "_ovf"}, 32'(sel ? ovf4 : ovf1), 32'(eo));
    check_eq({tag, "_busy_dn"}, 32'(sel ? busy4 : busy1), 32'd0);
    prev_sum[sel] = es;
    @(negedge clk);
    check_eq({tag, "_pulse"}, 32'(sel ? done4 : done1), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nd_seen;
    int cyc;
    reset_n = 1'b0; start1 = 1'b0; start4 = 1'b0;
    sub = 1'b0; cin = 1'b0; a = 8'h00; b = 8'h00;
    prev_sum[0] = 8'h00; prev_sum[1] = 8'h00;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", 32'(busy1), 32'd0);
    check_eq("rst_done", 32'(done1), 32'd0);
    check_eq("rst_sum", 32'(sum1), 32'd0);
    check_eq("rst_flags", 32'({cout1, ovf1, cout4, ovf4}), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("idle_busy", 32'(busy1 | busy4), 32'd0);

    run_op("add_ovf",   1'b0, 8'd100, 8'd55,  1'b0, 1'b0, 8'd155, 1'b0, 1'b1);
    run_op("add_cin",   1'b0, 8'd200, 8'd100, 1'b0, 1'b1, 8'd45,  1'b1, 1'b0);
    run_op("sub_neg",   1'b0, 8'd5,   8'd7,   1'b1, 1'b0, 8'hFE,  1'b0, 1'b0);
    run_op("sub_cin_x", 1'b0, 8'd5,   8'd7,   1'b1, 1'b1, 8'hFE,  1'b0, 1'b0);
    run_op("sub_ovf",   1'b0, 8'h80,  8'h01,  1'b1, 1'b0, 8'h7F,  1'b1, 1'b1);

    repeat (5) @(negedge clk);
    check_eq("idle_hold", 32'({sum1, cout1, ovf1}), 32'({8'h7F, 1'b1, 1'b1}));

    run_op("n_wrap",    1'b1, 8'hFF,  8'h01,  1'b0, 1'b0, 8'h00,  1'b1, 1'b0);
    run_op("n_sub",     1'b1, 8'h10,  8'h20,  1'b1, 1'b0, 8'hF0,  1'b0, 1'b0);
    run_op("n_sub_ovf", 1'b1, 8'h7F,  8'hFF,  1'b1, 1'b0, 8'h80,  1'b0, 1'b1);

    // Start held high: one result every 9 cycles, single-cycle done each time.
    @(negedge clk);
    a = 8'd1; b = 8'd2; sub = 1'b0; cin = 1'b0; start1 = 1'b1;
    nd_seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done1) begin
        check_eq("bb_idx", 32'(i), 32'(8 + 9 * nd_seen));
        check_eq("bb_sum", 32'(sum1), 32'd3);
        nd_seen++;
      end
    end
    check_eq("bb_count", 32'(nd_seen), 32'd3);
    start1 = 1'b0;
    cyc = 0;
    while (!done1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("bb_drain", 32'(done1), 32'd1);
    prev_sum[0] = 8'd3;
    @(negedge clk);

    // Async reset during the 4th RUN cycle aborts the operation.
    run_op("pre_rst", 1'b0, 8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1);
    @(negedge clk);
    a = 8'd3; b = 8'd4; sub = 1'b0; cin = 1'b0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_eq("arst_busy", 32'(busy1), 32'd0);
    check_eq("arst_done", 32'(done1), 32'd0);
    check_eq("arst_sum", 32'(sum1), 32'd0);
    check_eq("arst_flags", 32'({cout1, ovf1}), 32'd0);
    check_eq("arst_sum4", 32'(sum4), 32'd0);
    prev_sum[0] = 8'h00; prev_sum[1] = 8'h00;
    @(negedge clk);
    reset_n = 1'b1;
    nd_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done1) nd_seen++;
    end
    check_eq("arst_nodone", 32'(nd_seen), 32'd0);
    check_eq("arst_idle", 32'({busy1, sum1}), 32'd0);

    run_op("post_rst", 1'b0, 8'd3, 8'd4, 1'b0, 1'b0, 8'd7, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
